// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC, req/ack instruction-memory reads, one-word buffer to IF/ID.
// Optional FETCH_PERF_EN adds perf_fetched / perf_dropped event counters.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        en,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst_out,
    output logic [31:0] pcplus4_out,
    output logic        valid_out,
    output logic [1:0]  dbg_state
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetched,
    output logic [31:0] perf_dropped
`endif
);

    // Handshake: a word transfers on any cycle where imem_req && imem_ack; imem_addr is
    // held while imem_req && !imem_ack. IF/ID takes the presented word on en && valid_out.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        VALID = 2'd1,
        DROP  = 2'd2
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] buf_inst;
    logic [31:0] buf_pc4;
    logic [31:0] drop_addr;
    logic [31:0] pc_next;
    logic [31:0] target_pc;

    assign pc_next   = pc + 32'd4;
    assign target_pc = redirect_pc & 32'hFFFF_FFFC;

    assign valid_out   = (state == VALID);
    assign inst_out    = valid_out ? buf_inst : 32'd0;
    assign pcplus4_out = valid_out ? buf_pc4 : 32'd0;
    assign imem_addr   = (state == DROP) ? drop_addr : pc;
    assign dbg_state   = state;

    // In VALID a request is only worth issuing when the buffer is about to free up.
    always_comb begin
        imem_req = 1'b0;
        case (state)
            FETCH:   imem_req = 1'b1;
            DROP:    imem_req = 1'b1;
            VALID:   imem_req = en && !redirect;
            default: imem_req = 1'b0;
        endcase
        imem_req = imem_req && reset_n;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= FETCH;
            pc        <= RESET_PC;
            buf_inst  <= 32'd0;
            buf_pc4   <= 32'd0;
            drop_addr <= 32'd0;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        pc <= target_pc;
                        if (!imem_ack) begin
                            drop_addr <= pc;
                            state     <= DROP;
                        end
                    end else if (imem_ack) begin
                        buf_inst <= imem_rdata;
                        buf_pc4  <= pc_next;
                        pc       <= pc_next;
                        state    <= VALID;
                    end
                end
                VALID: begin
                    if (redirect) begin
                        pc    <= target_pc;
                        state <= FETCH;
                    end else if (en) begin
                        if (imem_ack) begin
                            buf_inst <= imem_rdata;
                            buf_pc4  <= pc_next;
                            pc       <= pc_next;
                        end else begin
                            state <= FETCH;
                        end
                    end
                end
                DROP: begin
                    // The stale transfer must finish at drop_addr before the new PC is used.
                    if (redirect) begin
                        pc <= target_pc;
                    end
                    if (imem_ack) begin
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic fetched_evt;
    logic dropped_evt;

    assign fetched_evt = (state == VALID) && en && !redirect;
    assign dropped_evt = ((state == VALID) && redirect)
                      || ((state == FETCH) && redirect && imem_ack)
                      || ((state == DROP) && imem_ack);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            perf_fetched <= 32'd0;
            perf_dropped <= 32'd0;
        end else begin
            if (fetched_evt) perf_fetched <= perf_fetched + 32'd1;
            if (dropped_evt) perf_dropped <= perf_dropped + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: reset, streaming, stall, redirects and PC wrap-around.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        en = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = 32'd0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst_out;
    logic [31:0] pcplus4_out;
    logic        valid_out;
    logic [1:0]  dbg_state;
    logic        zero_wait = 1'b0;
    logic        ack_drv = 1'b0;

    logic        en_w = 1'b0;
    logic        w_req;
    logic [31:0] w_addr;
    logic        w_ack;
    logic [31:0] w_rdata;
    logic [31:0] w_inst;
    logic [31:0] w_pc4;
    logic        w_valid;
    logic [1:0]  w_state;

    int n_checks = 0;
    int n_errors = 0;

`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched, perf_dropped;
    logic [31:0] w_perf_fetched, w_perf_dropped;
`endif

    // Memory image: word at address a holds 0x8C010000 + a.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'h8C01_0000 + a;
    endfunction

    assign imem_ack   = zero_wait ? imem_req : ack_drv;
    assign imem_rdata = mem_word(imem_addr);
    assign w_ack      = w_req;
    assign w_rdata    = mem_word(w_addr);

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .reset_n(reset_n), .en(en), .redirect(redirect),
        .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_out(inst_out),
        .pcplus4_out(pcplus4_out), .valid_out(valid_out), .dbg_state(dbg_state)
`ifdef FETCH_PERF_EN
        , .perf_fetched(perf_fetched), .perf_dropped(perf_dropped)
`endif
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .reset_n(reset_n), .en(en_w), .redirect(1'b0),
        .redirect_pc(32'd0), .imem_req(w_req), .imem_addr(w_addr),
        .imem_ack(w_ack), .imem_rdata(w_rdata), .inst_out(w_inst),
        .pcplus4_out(w_pc4), .valid_out(w_valid), .dbg_state(w_state)
`ifdef FETCH_PERF_EN
        , .perf_fetched(w_perf_fetched), .perf_dropped(w_perf_dropped)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic apply_reset();
        @(negedge clk);
        reset_n = 1'b0; en = 1'b0; redirect = 1'b0; redirect_pc = 32'd0;
        zero_wait = 1'b0; ack_drv = 1'b0; en_w = 1'b0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || inst_out !== 32'd0 || pcplus4_out !== 32'd0 || imem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_outputs: got v=%0b i=%h p=%h r=%0b want 0 0 0 0", valid_out, inst_out, pcplus4_out, imem_req);
        end
        @(negedge clk);
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || dbg_state !== 2'd0) begin
            n_errors++;
            $display("FAIL reset_release: got r=%0b a=%h s=%0d want 1 0 0", imem_req, imem_addr, dbg_state);
        end
        ack_drv = 1'b1;
        @(negedge clk);
        ack_drv = 1'b0;
        #1;
        n_checks++;
        if (valid_out !== 1'b1 || inst_out !== 32'h8C01_0000 || pcplus4_out !== 32'h4) begin
            n_errors++;
            $display("FAIL first_word: got v=%0b i=%h p=%h want 1 8c010000 4", valid_out, inst_out, pcplus4_out);
        end
        en = 1'b1;
        reset_n = 1'b0;
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || inst_out !== 32'd0 || pcplus4_out !== 32'd0 || imem_req !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_midfetch: got v=%0b i=%h p=%h r=%0b want 0 0 0 0", valid_out, inst_out, pcplus4_out, imem_req);
        end
        @(negedge clk);
        en = 1'b0;
        reset_n = 1'b1;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h0 || valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL rerelease: got r=%0b a=%h v=%0b want 1 0 0", imem_req, imem_addr, valid_out);
        end
    endtask

    task automatic test_stream();
        logic [31:0] exp_inst [3] = '{32'h8C01_0000, 32'h8C01_0004, 32'h8C01_0008};
        logic [31:0] exp_pc4  [3] = '{32'h4, 32'h8, 32'hC};
        apply_reset();
        zero_wait = 1'b1;
        en = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (valid_out !== 1'b1 || inst_out !== exp_inst[i] || pcplus4_out !== exp_pc4[i]) begin
                n_errors++;
                $display("FAIL stream[%0d]: got v=%0b i=%h p=%h want 1 %h %h", i, valid_out, inst_out, pcplus4_out, exp_inst[i], exp_pc4[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_hold();
        apply_reset();
        zero_wait = 1'b1;
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++;
            if (valid_out !== 1'b1 || inst_out !== 32'h8C01_0004 || pcplus4_out !== 32'h8 ||
                imem_req !== 1'b0 || imem_addr !== 32'h8) begin
                n_errors++;
                $display("FAIL hold[%0d]: got v=%0b i=%h p=%h r=%0b a=%h want 1 8c010004 8 0 8", i, valid_out, inst_out, pcplus4_out, imem_req, imem_addr);
            end
            @(negedge clk);
        end
        en = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (valid_out !== 1'b1 || inst_out !== 32'h8C01_0008 || pcplus4_out !== 32'hC) begin
            n_errors++;
            $display("FAIL hold_resume: got v=%0b i=%h p=%h want 1 8c010008 c", valid_out, inst_out, pcplus4_out);
        end
        en = 1'b0;
    endtask

    task automatic test_redirect_inflight();
        apply_reset();
        zero_wait = 1'b1;
        en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        zero_wait = 1'b0;
        ack_drv = 1'b0;
        @(negedge clk);
        for (int cyc = 0; cyc < 4; cyc++) begin
            redirect = (cyc == 1);
            redirect_pc = 32'h40;
            ack_drv = (cyc == 3);
            #1;
            n_checks++;
            if (imem_req !== 1'b1 || imem_addr !== 32'h8 || valid_out !== 1'b0) begin
                n_errors++;
                $display("FAIL inflight[%0d]: got r=%0b a=%h v=%0b want 1 8 0", cyc, imem_req, imem_addr, valid_out);
            end
            @(negedge clk);
        end
        redirect = 1'b0;
        ack_drv = 1'b0;
        #1;
        n_checks++;
        if (imem_req !== 1'b1 || imem_addr !== 32'h40 || valid_out !== 1'b0) begin
            n_errors++;
            $display("FAIL inflight_next: got r=%0b a=%h v=%0b want 1 40 0", imem_req, imem_addr, valid_out);
        end
`ifdef FETCH_PERF_EN
        n_checks++;
        if (perf_dropped !== 32'd1) begin
            n_errors++;
            $display("FAIL perf_drop: got %0d want 1", perf_dropped);
        end
`endif
        @(negedge clk);
        zero_wait = 1'b1;
        @(negedge clk);
        #1;
        n_checks++;
        if (valid_out !== 1'b1 || inst_out !== 32'h8C01_0040 || pcplus4_out !== 32'h44) begin
            n_errors++;
            $display("FAIL inflight_data: got v=%0b i=%h p=%h want 1 8c010040 44", valid_out, inst_out, pcplus4_out);
        end
`ifdef FETCH_PERF_EN
        for (int i = 0; i < 3; i++) @(negedge clk);
        #1;
        n_checks++;
        if (perf_fetched !== 32'd5 || perf_dropped !== 32'd1) begin
            n_errors++;
            $display("FAIL perf_counts: got f=%0d d=%0d want 5 1", perf_fetched, perf_dropped);
        end
`endif
        en = 1'b0;
        zero_wait = 1'b0;
    endtask

    task automatic test_redirect_valid();
        apply_reset();
        zero_wait = 1'b1;
        en = 1'b1;
        @(negedge clk);
        zero_wait = 1'b0;
        ack_drv = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        #1;
        n_checks++;
        if (imem_req !== 1'b0 || valid_out !== 1'b1) begin
            n_errors++;
            $display("FAIL redir_valid_req: got r=%0b v=%0b want 0 1", imem_req, valid_out);
        end
        @(negedge clk);
        redirect_pc = 32'h200;
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || inst_out !== 32'd0 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
            n_errors++;
            $display("FAIL redir_align: got v=%0b i=%h r=%0b a=%h want 0 0 1 100", valid_out, inst_out, imem_req, imem_addr);
        end
        @(negedge clk);
        redirect = 1'b0;
        ack_drv = 1'b0;
        #1;
        n_checks++;
        if (valid_out !== 1'b0 || imem_addr !== 32'h200) begin
            n_errors++;
            $display("FAIL redir_fetch_ack: got v=%0b a=%h want 0 200", valid_out, imem_addr);
        end
        @(negedge clk);
        zero_wait = 1'b1;
        @(negedge clk);
        en = 1'b0;
        #1;
        n_checks++;
        if (valid_out !== 1'b1 || inst_out !== 32'h8C01_0200 || pcplus4_out !== 32'h204) begin
            n_errors++;
            $display("FAIL redir_data: got v=%0b i=%h p=%h want 1 8c010200 204", valid_out, inst_out, pcplus4_out);
        end
        zero_wait = 1'b0;
    endtask

    task automatic test_wrap();
        apply_reset();
        #1;
        n_checks++;
        if (w_req !== 1'b1 || w_addr !== 32'hFFFF_FFFC) begin
            n_errors++;
            $display("FAIL wrap_addr: got r=%0b a=%h want 1 fffffffc", w_req, w_addr);
        end
        @(negedge clk);
        #1;
        n_checks++;
        if (w_valid !== 1'b1 || w_pc4 !== 32'h0 || w_inst !== 32'h8C00_FFFC || w_req !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_word: got v=%0b p=%h i=%h r=%0b want 1 0 8c00fffc 0", w_valid, w_pc4, w_inst, w_req);
        end
        en_w = 1'b1;
        #1;
        n_checks++;
        if (w_req !== 1'b1 || w_addr !== 32'h0) begin
            n_errors++;
            $display("FAIL wrap_next: got r=%0b a=%h want 1 0", w_req, w_addr);
        end
        en_w = 1'b0;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_hold();
        test_redirect_inflight();
        test_redirect_valid();
        test_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
